// File: rtl/regfile_write_arbiter_pkg.sv
// Shared pipeline types for the register-file write-port arbiter.
// Latency: none (types and helpers only).
// Backpressure: n/a.
package regfile_write_arbiter_pkg;

  typedef logic [4:0]  reg_t;
  typedef logic [31:0] int_t;

  // One queued MDU result; valid drops when a younger WB write hits the same dst.
  typedef struct packed {
    logic valid;
    reg_t dst;
    int_t value;
  } wbarb_entry_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } wbarb_state_t;

  localparam reg_t REG_ZERO = 5'd0;

  // A write only reaches the port when it targets a real register ($0 is hardwired).
  function automatic logic is_effective(input logic we, input reg_t dst);
    return we && (dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of WB, MDU and register-file port signals around the write arbiter.
// Latency: none (wiring only).
// Backpressure: mdu_ready back to the MDU, stall_req back to the pipeline.
interface regfile_write_arbiter_if;
  import regfile_write_arbiter_pkg::*;

  logic wb_write_enable;
  reg_t wb_reg_dst;
  int_t wb_write_value;
  logic wb_syscall;
  logic mdu_valid;
  logic mdu_ready;
  reg_t mdu_reg_dst;
  int_t mdu_value;
  logic rf_write_enable;
  reg_t rf_reg_dst;
  int_t rf_write_value;
  logic stall_req;
  logic halted;

  modport master (
    output wb_write_enable, wb_reg_dst, wb_write_value, wb_syscall,
    output mdu_valid, mdu_reg_dst, mdu_value,
    input  mdu_ready, rf_write_enable, rf_reg_dst, rf_write_value, stall_req, halted
  );

  modport slave (
    input  wb_write_enable, wb_reg_dst, wb_write_value, wb_syscall,
    input  mdu_valid, mdu_reg_dst, mdu_value,
    output mdu_ready, rf_write_enable, rf_reg_dst, rf_write_value, stall_req, halted
  );

endinterface

// File: rtl/regfile_write_arbiter_fifo.sv
// Circular MDU result buffer with per-entry valid bits and squash-by-dst.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
module wbarb_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  reg_t          push_dst_i,
  input  int_t          push_value_i,
  input  logic          pop_i,
  input  logic          squash_i,
  input  reg_t          squash_dst_i,
  output wbarb_entry_t  head_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  wbarb_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer/count next state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  // Pointer/count registers; reset discards anything still queued.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage: squash matching entries, then write the new entry (its slot is free, so it stays valid).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_i && (mem_q[i].dst == squash_dst_i)) mem_q[i].valid <= 1'b0;
      end
      if (do_push) mem_q[wr_ptr_q] <= '{valid: 1'b1, dst: push_dst_i, value: push_value_i};
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the RF write port: WB wins, MDU results queue and drain into idle WB slots; SYSCALL drains then halts.
// Latency: WB same cycle; MDU >=1 cycle via the FIFO (0 cycles when WBARB_BYPASS_EN is defined and the path is idle).
// Backpressure: mdu_ready low when full or not in RUN; stall_req requests a bubble on starvation and during drain.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  wbarb_state_t  state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          stall_q, stall_d;

  wbarb_entry_t  head;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count, count_next;
  logic          wb_eff, accept, bypass, push, pop, empty_next;

  assign wb_eff        = is_effective(bus.wb_write_enable, bus.wb_reg_dst);
  assign bus.mdu_ready = !fifo_full && (state_q == RUN);
  assign accept        = bus.mdu_valid && bus.mdu_ready;
`ifdef WBARB_BYPASS_EN
  assign bypass        = accept && fifo_empty && !wb_eff && (bus.mdu_reg_dst != REG_ZERO);
`else
  assign bypass        = 1'b0;
`endif
  // Results to $0 are accepted and dropped; bypassed results never enter the FIFO.
  assign push          = accept && !bypass && (bus.mdu_reg_dst != REG_ZERO);
  assign pop           = !fifo_empty && !wb_eff;
  assign count_next    = fifo_count + CW'(push) - CW'(pop);
  assign empty_next    = (count_next == '0);

  wbarb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_i       (push),
    .push_dst_i   (bus.mdu_reg_dst),
    .push_value_i (bus.mdu_value),
    .pop_i        (pop),
    .squash_i     (wb_eff),
    .squash_dst_i (bus.wb_reg_dst),
    .head_o       (head),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .count_o      (fifo_count)
  );

  // Port mux: WB first, then FIFO head (squashed heads pop silently), then optional bypass.
  always_comb begin
    bus.rf_write_enable = 1'b0;
    bus.rf_reg_dst      = '0;
    bus.rf_write_value  = '0;
    if (wb_eff) begin
      bus.rf_write_enable = 1'b1;
      bus.rf_reg_dst      = bus.wb_reg_dst;
      bus.rf_write_value  = bus.wb_write_value;
    end else if (pop) begin
      bus.rf_write_enable = head.valid;
      bus.rf_reg_dst      = head.dst;
      bus.rf_write_value  = head.value;
    end else if (bypass) begin
      bus.rf_write_enable = 1'b1;
      bus.rf_reg_dst      = bus.mdu_reg_dst;
      bus.rf_write_value  = bus.mdu_value;
    end
    if (reset) bus.rf_write_enable = 1'b0;
  end

  // Starvation tracking: count unserviced cycles, raise stall one cycle after the limit is reached.
  always_comb begin
    wait_d  = wait_q;
    stall_d = stall_q;
    if (fifo_empty || pop) wait_d = '0;
    else if (wait_q != WW'(STARVE_LIMIT)) wait_d = wait_q + WW'(1);
    if (pop) stall_d = 1'b0;
    else if (!fifo_empty && ((32'(wait_q) + 1) >= (STARVE_LIMIT - 1))) stall_d = 1'b1;
  end

  // FSM next state and outputs; leave DRAIN on the edge that retires the last entry.
  always_comb begin
    state_d       = state_q;
    bus.stall_req = stall_q;
    bus.halted    = 1'b0;
    case (state_q)
      RUN:     if (bus.wb_syscall) state_d = empty_next ? HALTED : DRAIN;
      DRAIN: begin
        bus.stall_req = 1'b1;
        if (empty_next) state_d = HALTED;
      end
      HALTED:  bus.halted = 1'b1;
      default: state_d = RUN;
    endcase
  end

  // State, wait counter and stall request registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between the pipeline write-back stage and the multi-cycle multiply/divide unit (MDU).
- WB writes always win the port; MDU results queue in a small FIFO and drain into idle WB slots.
- A starvation counter requests a pipeline bubble when the FIFO waits too long.
- A SYSCALL in WB drains the FIFO before the halt is reported, so no result is lost at end of simulation.

Parameters:
- DEPTH, 4, MDU result FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 8, cycles a non-empty FIFO may go unserviced before stall_req asserts (≥1).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wb_write_enable  in  1  WB stage register write request
- wb_reg_dst  in  5  WB destination register (reg_t)
- wb_write_value  in  32  WB result (int_t)
- wb_syscall  in  1  WB instruction is SYSCALL
- mdu_valid  in  1  MDU result available
- mdu_ready  out  1  arbiter accepts MDU result this cycle
- mdu_reg_dst  in  5  MDU destination register
- mdu_value  in  32  MDU result
- rf_write_enable  out  1  register file write enable
- rf_reg_dst  out  5  register file write address
- rf_write_value  out  32  register file write data
- stall_req  out  1  request one pipeline bubble so the FIFO can drain
- halted  out  1  SYSCALL seen and all pending writes retired

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- Reset values: FIFO empty, wait_cnt=0, state=RUN, stall_req=0, halted=0. rf_write_enable=0 while reset is high.
- A WB write is "effective" when wb_write_enable=1 and wb_reg_dst≠0. Writes to $0 are never driven to the port (rf_write_enable=0).
- Port select (combinational):
  - Effective WB write → port carries WB.
  - Otherwise, FIFO non-empty → port carries FIFO head; head pops at the clock edge.
  - Otherwise → rf_write_enable=0.
- Push: mdu_valid & mdu_ready enqueues {dst, value} at the clock edge, one-cycle minimum MDU-to-port latency. mdu_ready = !full & (state==RUN). No push when full; no same-cycle push-through when full.
- MDU result to $0: accepted but not enqueued.
- Squash: an effective WB write whose dst matches a pending FIFO entry invalidates that entry (WB is younger in program order). Invalid entries pop without asserting rf_write_enable; the pop still takes its cycle.
- Starvation:
  - wait_cnt increments each cycle the FIFO is non-empty and no pop occurs; it clears on any pop or when the FIFO is empty.
  - stall_req is registered: set when wait_cnt reaches STARVE_LIMIT-1 and no pop this cycle; cleared after the cycle in which a pop occurs.
  - Upstream guarantees wb_write_enable=0 the cycle after stall_req is seen high.
- Simultaneous push and pop: both happen; count is unchanged.
- FSM:
  - RUN→DRAIN on wb_syscall=1. A WB write in that same cycle is still honoured.
  - DRAIN: mdu_ready=0, stall_req=1; pop one entry per cycle. When empty → HALTED.
  - HALTED: halted=1, absorbing until reset; rf_write_enable=0 except for effective WB writes.
  - A SYSCALL arriving with the FIFO empty reaches HALTED on the next edge.
- Reset asserted mid-drain: all state clears immediately; pending entries are discarded.

Optional Feature:
- Macro: WBARB_BYPASS_EN.
- Defined: when the FIFO is empty, WB is not effective, and mdu_valid=1 in RUN, the MDU result drives the port in the same cycle and is not enqueued (zero latency).
- Undefined: every MDU result passes through the FIFO (minimum 1-cycle latency).

Decomposition:
- Shared pipeline definitions package holds: reg_t and int_t (reused), wbarb_entry_t {valid, dst, value}, and wbarb_state_t {RUN, DRAIN, HALTED}.
- One sub-module: wbarb_fifo, a circular buffer with per-entry valid bits and an associative squash-by-dst input. Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH)+1.

Test Plan:
- MDU push dst=5 val=0xAA while WB idle → next cycle rf_write_enable=1, rf_reg_dst=5, value 0xAA. With WBARB_BYPASS_EN, same cycle.
- WB writes every cycle, MDU pushes dst=7 once, STARVE_LIMIT=8 → stall_req high on cycle 8. The bubble cycle writes dst=7, and stall_req drops the following cycle.
- Fill 4 MDU results with WB busy → mdu_ready=0 at count 4. One idle WB slot pops the head and mdu_ready returns to 1.
- MDU enqueues dst=3 val=1, then WB writes dst=3 val=2 → the entry is squashed. Final r3=2, and no later write to r3 occurs.
- 3 entries pending, wb_syscall=1 → mdu_ready=0, 3 drain writes in order, then halted=1 on the 4th edge.
- Assert reset during DRAIN with 2 entries → rf_write_enable=0 immediately. After reset: halted=0, FIFO empty, no stray writes.
